imm_gen_pipe: RTL and testbench

// - Pipelined, parametrised RV immediate generator. It takes the full 32-bit instruction word,

---
 rtl/imm_gen_pipe.sv | 173 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV immediate generator, valid/ready on both sides.
// Decode is combinational at the input; the last of PIPE_DEPTH stages drives the outputs.
module imm_gen_pipe #(
   parameter int XLEN       = 32,
   parameter int PIPE_DEPTH = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            unsigned_en,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_out,
   output logic [2:0]      fmt,
   output logic            illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
   end
   if (PIPE_DEPTH != 1 && PIPE_DEPTH != 2) begin : g_bad_depth
      $fatal(1, "imm_gen_pipe: PIPE_DEPTH must be 1 or 2");
   end

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam int         SH_W      = (XLEN == 64) ? 6 : 5;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } stage_t;

   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_opimm;
   logic        is_shift;
   logic        is_ilike;
   logic        is_jalr;
   logic        is_store;
   logic        is_branch;
   logic        is_upper;
   logic        is_jal;
   logic [31:0] i_s;
   logic [31:0] i_u;
   logic [31:0] s_s;
   logic [31:0] b_s;
   logic [31:0] u_s;
   logic [31:0] j_s;
   logic [XLEN-1:0] sh;
   stage_t      dec;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign is_opimm  = (opcode == 7'b0010011);
   assign is_shift  = is_opimm && (funct3 == 3'b001 || funct3 == 3'b101);
   assign is_ilike  = (is_opimm && !is_shift) || (opcode == 7'b0000011);
   assign is_jalr   = (opcode == 7'b1100111);
   assign is_store  = (opcode == 7'b0100011);
   assign is_branch = (opcode == 7'b1100011);
   assign is_upper  = (opcode == 7'b0110111) || (opcode == 7'b0010111);
   assign is_jal    = (opcode == 7'b1101111);

   assign i_s = {{20{instr[31]}}, instr[31:20]};
   assign i_u = {20'b0, instr[31:20]};
   assign s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign b_s = {{20{instr[31]}}, instr[7], instr[30:25],
                 instr[11:8], 1'b0};
   assign u_s = {instr[31:12], 12'b0};
   assign j_s = {{12{instr[31]}}, instr[19:12], instr[20],
                 instr[30:21], 1'b0};
   // funct7/funct6 sit above the shamt field and are dropped here
   assign sh  = {{(XLEN-SH_W){1'b0}}, instr[20 +: SH_W]};

   always_comb begin
      dec = '0;
      unique case (1'b1)
         is_shift: begin
            dec.imm = sh;
            dec.fmt = FMT_SHAMT;
         end
         is_ilike: begin
            dec.imm = unsigned_en ? XLEN'(i_u) : sext(i_s);
            dec.fmt = FMT_I;
         end
         is_jalr: begin
            dec.imm = sext(i_s);
            dec.fmt = FMT_I;
         end
         is_store: begin
            dec.imm = sext(s_s);
            dec.fmt = FMT_S;
         end
         is_branch: begin
            dec.imm = sext(b_s);
            dec.fmt = FMT_B;
         end
         is_upper: begin
            dec.imm = sext(u_s);
            dec.fmt = FMT_U;
         end
         is_jal: begin
            dec.imm = sext(j_s);
            dec.fmt = FMT_J;
         end
         default: begin
            dec.fmt     = FMT_NONE;
            dec.illegal = 1'b1;
         end
      endcase
   end

   stage_t s0;
   stage_t s_last;
   logic   v0;
   logic   go0;
   logic   v_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0 <= 1'b0;
         s0 <= '0;
      end else if (go0) begin
         v0 <= in_valid;
         if (in_valid) s0 <= dec;
      end
   end

   if (PIPE_DEPTH == 1) begin : g_d1
      assign go0    = !v0 || out_ready;
      assign v_last = v0;
      assign s_last = s0;
   end else begin : g_d2
      stage_t s1;
      logic   v1;
      logic   go1;

      assign go1 = !v1 || out_ready;
      assign go0 = !v0 || go1;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
         end else if (go1) begin
            v1 <= v0;
            if (v0) s1 <= s0;
         end
      end

      assign v_last = v1;
      assign s_last = s1;
   end

   assign in_ready  = go0;
   assign out_valid = v_last;
   assign imm_out   = s_last.imm;
   assign fmt       = s_last.fmt;
   assign illegal   = s_last.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: config 0 is XLEN=32/depth 1, config 1 is XLEN=64/depth 2.
// Table vectors, backpressure and reset sequences, and a scoreboarded random stream.
module tb_imm_gen_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } res_t;

   typedef struct {
      int          c;
      logic [31:0] instr;
      logic        uns;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid[2];
   logic        in_ready[2];
   logic        unsigned_en[2];
   logic        out_valid[2];
   logic        out_ready[2];
   logic        illegal[2];
   logic [31:0] instr[2];
   logic [2:0]  fmt[2];
   logic [31:0] imm32;
   logic [63:0] imm64;

   int   pass_cnt = 0;
   int   total = 0;
   int   n_in[2];
   int   n_out[2];
   res_t q0[$];
   res_t q1[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .instr(instr[0]), .unsigned_en(unsigned_en[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .imm_out(imm32), .fmt(fmt[0]), .illegal(illegal[0])
   );

   imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(2)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .instr(instr[1]), .unsigned_en(unsigned_en[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .imm_out(imm64), .fmt(fmt[1]), .illegal(illegal[1])
   );

   function automatic int depth(int c);
      return (c == 1) ? 2 : 1;
   endfunction

   function automatic int xlen(int c);
      return (c == 1) ? 64 : 32;
   endfunction

   function automatic logic [63:0] imm_of(int c);
      return (c == 1) ? imm64 : {32'b0, imm32};
   endfunction

   function automatic int qsize(int c);
      return (c == 1) ? q1.size() : q0.size();
   endfunction

   // Reference built from field arithmetic on the instruction word
   function automatic res_t model(int xl, logic [31:0] ins, logic uns);
      res_t   r;
      longint si;
      longint ui;
      longint x;
      logic [2:0] f3;
      si = longint'($signed(ins));
      ui = longint'({32'b0, ins});
      f3 = ins[14:12];
      x = 0;
      r.fmt = 3'd0;
      r.ill = 1'b0;
      case (ins[6:0])
         7'h13: begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
               r.fmt = 3'd6;
               x = (ui >> 20) % xl;
            end else begin
               r.fmt = 3'd1;
               x = uns ? (ui >> 20) : (si >>> 20);
            end
         end
         7'h03: begin
            r.fmt = 3'd1;
            x = uns ? (ui >> 20) : (si >>> 20);
         end
         7'h67: begin
            r.fmt = 3'd1;
            x = si >>> 20;
         end
         7'h23: begin
            r.fmt = 3'd2;
            x = (si >>> 25) * 32 + (ui >> 7) % 32;
         end
         7'h63: begin
            r.fmt = 3'd3;
            x = (si >>> 31) * 4096 + ((ui >> 7) % 2) * 2048
              + ((ui >> 25) % 64) * 32 + ((ui >> 8) % 16) * 2;
         end
         7'h37, 7'h17: begin
            r.fmt = 3'd4;
            x = (si >>> 12) * 4096;
         end
         7'h6F: begin
            r.fmt = 3'd5;
            x = (si >>> 31) * (1 << 20) + ((ui >> 12) % 256) * 4096
              + ((ui >> 20) % 2) * 2048 + ((ui >> 21) % 1024) * 2;
         end
         default: begin
            r.ill = 1'b1;
            x = 0;
         end
      endcase
      r.imm = (xl == 32) ? {32'b0, x[31:0]} : x;
      return r;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[6:0] = 7'h13;
         1: r[6:0] = 7'h03;
         2: r[6:0] = 7'h67;
         3: r[6:0] = 7'h23;
         4: r[6:0] = 7'h63;
         5: r[6:0] = 7'h37;
         6: r[6:0] = 7'h17;
         7: r[6:0] = 7'h6F;
         8: begin
            r[6:0]   = 7'h13;
            r[13:12] = 2'b01;
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic add(int c, logic [31:0] i, logic u,
                      logic [63:0] im, logic [2:0] f, logic il);
      vec_t v;
      v.c = c; v.instr = i; v.uns = u;
      v.imm = im; v.fmt = f; v.ill = il;
      vecs.push_back(v);
   endtask

   // One cycle: drive at negedge, score the transfers of the coming edge
   task automatic step(int c, logic v, logic [31:0] ins,
                       logic uns, logic ordy);
      res_t e;
      in_valid[c] = v;
      instr[c] = ins;
      unsigned_en[c] = uns;
      out_ready[c] = ordy;
      #1;
      if (out_valid[c] && out_ready[c]) begin
         n_out[c]++;
         if (qsize(c) == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            if (c == 1) e = q1.pop_front();
            else e = q0.pop_front();
            chk("stream_imm", imm_of(c), e.imm);
            chk("stream_fmt", {fmt[c], illegal[c]}, {e.fmt, e.ill});
         end
      end
      if (in_valid[c] && in_ready[c]) begin
         n_in[c]++;
         e = model(xlen(c), ins, uns);
         if (c == 1) q1.push_back(e);
         else q0.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(int c);
      for (int k = 0; k < 10 && qsize(c) > 0; k++) step(c, 0, 0, 0, 1);
      chk("drain_empty", qsize(c), 0);
   endtask

   task automatic send_one(int c, vec_t v);
      int lat;
      in_valid[c] = 1'b1;
      instr[c] = v.instr;
      unsigned_en[c] = v.uns;
      out_ready[c] = 1'b1;
      #1;
      chk("in_ready_idle", in_ready[c], 1);
      @(posedge clk);
      @(negedge clk);
      in_valid[c] = 1'b0;
      lat = 1;
      #1;
      while (!out_valid[c] && lat < 8) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, depth(c));
      chk("vec_imm", imm_of(c), v.imm);
      chk("vec_fmt", {fmt[c], illegal[c]}, {v.fmt, v.ill});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] b[3];
      logic [63:0] held_imm;
      logic [3:0]  held_meta;
      int          acc0;
      int          o0;
      int          i0;

      for (int c = 0; c < 2; c++) begin
         in_valid[c] = 0; instr[c] = 0;
         unsigned_en[c] = 0; out_ready[c] = 0;
         n_in[c] = 0; n_out[c] = 0;
      end

      add(0, 32'hFFF00093, 0, 64'hFFFFFFFF, 1, 0);
      add(0, 32'hFFF00093, 1, 64'h00000FFF, 1, 0);
      add(0, 32'hFE112E23, 0, 64'hFFFFFFFC, 2, 0);
      add(0, 32'hFE112E23, 1, 64'hFFFFFFFC, 2, 0);
      add(0, 32'hFE000CE3, 0, 64'hFFFFFFF8, 3, 0);
      add(0, 32'h0010006F, 0, 64'h00000800, 5, 0);
      add(0, 32'hFFF00067, 1, 64'hFFFFFFFF, 1, 0);
      add(0, 32'h80002003, 1, 64'h00000800, 1, 0);
      add(0, 32'h80002003, 0, 64'hFFFFF800, 1, 0);
      add(0, 32'h4230D093, 0, 64'h00000003, 6, 0);
      add(0, 32'h800000B7, 0, 64'h80000000, 4, 0);
      add(0, 32'h00000000, 0, 64'h0, 0, 1);
      add(0, 32'h00000091, 0, 64'h0, 0, 1);
      add(1, 32'h800000B7, 0, 64'hFFFFFFFF80000000, 4, 0);
      add(1, 32'h4030D093, 0, 64'h3, 6, 0);
      add(1, 32'h4230D093, 0, 64'h23, 6, 0);
      add(1, 32'h00000000, 0, 64'h0, 0, 1);
      add(1, 32'hFFF00093, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
      add(1, 32'hFFF00093, 1, 64'h0000000000000FFF, 1, 0);
      add(1, 32'hFE000CE3, 0, 64'hFFFFFFFFFFFFFFF8, 3, 0);

      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         chk("reset_out_valid", out_valid[c], 0);
         chk("reset_imm", imm_of(c), 0);
         chk("reset_fmt", {fmt[c], illegal[c]}, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset0", in_ready[0], 1);
      chk("in_ready_after_reset1", in_ready[1], 1);
      @(negedge clk);

      foreach (vecs[k]) send_one(vecs[k].c, vecs[k]);

      // Backpressure on the two-deep pipe
      for (int k = 0; k < 3; k++) b[k] = rnd_instr();
      acc0 = n_in[1];
      for (int k = 0; k < 4; k++) begin
         step(1, 1, b[n_in[1] - acc0 > 2 ? 2 : n_in[1] - acc0],
              1'(k), 0);
      end
      chk("bp_accepted", n_in[1] - acc0, 2);
      in_valid[1] = 1'b1;
      instr[1] = b[2];
      #1;
      chk("bp_in_ready_low", in_ready[1], 0);
      chk("bp_out_valid", out_valid[1], 1);
      held_imm = imm_of(1);
      held_meta = {fmt[1], illegal[1]};
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, b[2], 0, 0);
         #1;
         chk("bp_hold_valid", out_valid[1], 1);
         chk("bp_hold_imm", imm_of(1), held_imm);
         chk("bp_hold_fmt", {fmt[1], illegal[1]}, held_meta);
      end
      @(negedge clk);
      o0 = n_out[1];
      for (int k = 0; k < 10 && (qsize(1) > 0 || n_in[1] - acc0 < 3); k++)
         step(1, n_in[1] - acc0 < 3, b[2], 0, 1);
      chk("bp_third_accepted", n_in[1] - acc0, 3);
      drain(1);
      chk("bp_total_out", n_out[1] - o0, 3);

      // Full-rate streaming
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < depth(c); k++)
            step(c, 1, rnd_instr(), 1'($urandom_range(0, 1)), 1);
         o0 = n_out[c];
         i0 = n_in[c];
         for (int k = 0; k < 20; k++)
            step(c, 1, rnd_instr(), 1'($urandom_range(0, 1)), 1);
         chk("thru_out", n_out[c] - o0, 20);
         chk("thru_in", n_in[c] - i0, 20);
         drain(c);
      end

      // Random valid/ready
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 300; k++)
            step(c, 1'($urandom_range(0, 1)), rnd_instr(),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
         drain(c);
      end

      // Asynchronous reset with data in flight
      for (int c = 0; c < 2; c++) begin
         in_valid[c] = 1'b1;
         instr[c] = 32'hFFF00093;
         unsigned_en[c] = 1'b0;
         out_ready[c] = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      in_valid[1] = 1'b0;
      #1;
      chk("pre_rst_valid0", out_valid[0], 1);
      chk("pre_rst_valid1", out_valid[1], 1);
      #1 rst = 1'b1;
      #1;
      for (int c = 0; c < 2; c++) begin
         chk("async_rst_valid", out_valid[c], 0);
         chk("async_rst_imm", imm_of(c), 0);
         chk("async_rst_fmt", {fmt[c], illegal[c]}, 0);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_one(0, vecs[4]);
      send_one(1, vecs[13]);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
